exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
Exception-resolution stage at the MEM boundary, directly upstream of the CP0 register file. Collects per-instruction exception flags, data-address alignment errors and synchronised hardware interrupts, and picks one winner per instruction. Drives CP0's excepttype, current-instruction-address, delay-slot and bad-address inputs, plus pipeline flush, redirect PC and memory-access cancel. Forwards pending WB-stage MTC0 writes so exception decisions never use stale Status/Cause/EPC.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET
SYNC_STAGES, 2, flop depth of the int_i synchroniser (minimum 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stall_i  in  1  MEM stage held; no exception may be taken
inst_valid_i  in  1  MEM holds a real instruction (not a bubble)
pc_i  in  32  PC of the MEM instruction
is_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
exc_flags_i  in  6  [0] fetch AdEL, [1] RI, [2] Ov, [3] syscall, [4] break, [5] eret
mem_read_i  in  1  load in MEM
mem_write_i  in  1  store in MEM
mem_addr_i  in  32  data address
mem_size_i  in  2  0 byte, 1 half, 2 word
int_i  in  6  asynchronous hardware interrupt lines
cp0_status_i  in  32  CP0 Status
cp0_cause_i  in  32  CP0 Cause
cp0_epc_i  in  32  CP0 EPC
wb_cp0_we_i  in  1  WB-stage MTC0 write enable
wb_cp0_waddr_i  in  5  WB-stage MTC0 register number
wb_cp0_data_i  in  32  WB-stage MTC0 data
excepttype_o  out  32  exception code to CP0
current_inst_addr_o  out  32  pc_i passthrough to CP0
is_in_delayslot_o  out  1  delay-slot passthrough to CP0
bad_addr_o  out  32  faulting address to CP0
flush_o  out  1  flush all stages up to and including MEM
newpc_o  out  32  redirect PC, valid while flush_o is high
mem_cancel_o  out  1  suppress data-memory access
int_sync_o  out  6  synchronised interrupts, fed to CP0 int_i

Behaviour:
- Reset (asynchronous, rst=1): synchroniser flops = 0, int_sync_o = 0, blackout_r = 0. Combinational outputs evaluate with all exceptions suppressed: excepttype_o=0, flush_o=0, newpc_o=0, mem_cancel_o=0.
- Synchroniser: int_i passes through SYNC_STAGES flops. A line asserted before edge N appears on int_sync_o after edge N+SYNC_STAGES-1.
- Forwarding: effective Status/Cause/EPC = WB data when wb_cp0_we_i=1 and waddr is 12, 13 or 14 respectively; otherwise the CP0 input.
  - For Cause, forward only bits [9:8].
  - Cause[15:10] is always taken from int_sync_o.
- int_pend = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
- Data misalignment (mem_read_i or mem_write_i only):
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
- take = inst_valid_i & ~stall_i & ~blackout_r. When take=0: excepttype_o=0, flush_o=0, mem_cancel_o=0.
- Priority when take=1, highest first (code, bad_addr_o):
  1. int_pend: 0x1
  2. fetch AdEL: 0x4, bad_addr_o=pc_i
  3. RI: 0xa
  4. Ov: 0xc
  5. syscall: 0x8
  6. break: 0x9
  7. load misaligned: 0x4, bad_addr_o=mem_addr_i
  8. store misaligned: 0x5, bad_addr_o=mem_addr_i
  9. eret: 0xe
  10. none: 0x0
- bad_addr_o = 0 when the selected code has no faulting address.
- flush_o = (excepttype_o != 0), same cycle, zero latency.
- newpc_o:
  - ERET: effective EPC;
  - any other exception: EXC_VECTOR;
  - when flush_o=0: 0.
- mem_cancel_o = flush_o. A faulting or interrupted load/store never reaches memory.
- Blackout: blackout_r <= flush_o on every edge. Exactly one cycle of suppression after a flush, which covers the CP0 EXL update landing.
- Stall with a pending exception: the exception is held (not taken) until the first cycle with stall_i=0, then taken once.
- Stall with an interrupt that deasserts before the stall ends: the interrupt is not taken.
- Reset mid-flush: blackout_r clears immediately; no residual flush.

Test Plan:
- Status=0x00000401, int_i[0] pulsed high for 4 cycles, valid instruction at pc 0xBFC00100 -> after 2 edges int_sync_o[0]=1; excepttype_o=0x1, flush_o=1, newpc_o=0xBFC00380 for 1 cycle; the next cycle is blacked out.
- Load word at mem_addr_i 0x80000002 -> excepttype_o=0x5? No: excepttype_o=0x4, bad_addr_o=0x80000002, mem_cancel_o=1. Store half at 0x80000003 -> excepttype_o=0x5.
- Flags RI, Ov and syscall all set together -> excepttype_o=0xa. Fetch AdEL added to the same stimulus -> excepttype_o=0x4, bad_addr_o=pc_i.
- ERET with cp0_epc_i=0x1000 while WB MTC0 writes EPC=0x2000 -> newpc_o=0x2000, excepttype_o=0xe.
- Syscall with stall_i=1 for 3 cycles -> no flush during the stall; exactly one flush pulse on the first unstalled cycle. Assert rst during the flush -> flush_o=0 and blackout_r=0 immediately.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Pipeline-to-exception-stage bundle: MEM instruction info, CP0 views,
// WB-stage MTC0 forwarding path, and the resolved exception outputs.
interface exc_ctrl_if;
   logic        stall_i;
   logic        inst_valid_i;
   logic [31:0] pc_i;
   logic        is_in_delayslot_i;
   logic [5:0]  exc_flags_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [31:0] mem_addr_i;
   logic [1:0]  mem_size_i;
   logic [5:0]  int_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic [31:0] bad_addr_o;
   logic        flush_o;
   logic [31:0] newpc_o;
   logic        mem_cancel_o;
   logic [5:0]  int_sync_o;

   // Pipeline side: drives the MEM instruction and CP0 state, consumes the decision.
   modport master (
      output stall_i, inst_valid_i, pc_i, is_in_delayslot_i, exc_flags_i,
             mem_read_i, mem_write_i, mem_addr_i, mem_size_i, int_i,
             cp0_status_i, cp0_cause_i, cp0_epc_i,
             wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
             flush_o, newpc_o, mem_cancel_o, int_sync_o
   );

   // Exception-resolution side.
   modport slave (
      input  stall_i, inst_valid_i, pc_i, is_in_delayslot_i, exc_flags_i,
             mem_read_i, mem_write_i, mem_addr_i, mem_size_i, int_i,
             cp0_status_i, cp0_cause_i, cp0_epc_i,
             wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
             flush_o, newpc_o, mem_cancel_o, int_sync_o
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception resolution at the MEM boundary: picks one exception per
// instruction, drives CP0 inputs, flush/redirect and memory cancel.
//
// Qualifier semantics: an instruction is eligible only in a cycle where
// inst_valid_i=1 and stall_i=0. A held (stalled) instruction keeps its
// exception pending combinationally and it is taken on the first unstalled
// cycle; nothing is latched, so an interrupt that drops during a stall is lost.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
   parameter int          SYNC_STAGES = 2   // must be >= 2
) (
   input logic       clk,
   input logic       rst,
   exc_ctrl_if.slave bus
);

   logic [5:0]  sync_q [SYNC_STAGES];
   logic        blackout_r;
   logic [31:0] status_eff;
   logic [31:0] cause_eff;
   logic [31:0] epc_eff;
   logic        int_pend;
   logic        misalign;
   logic        load_mis;
   logic        store_mis;
   logic        take;
   logic [31:0] code;
   logic [31:0] bad_addr;
   logic        flush;
   logic        unused_bits;

   // Interrupt synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.int_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // One-cycle suppression after a flush while CP0 EXL update lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) blackout_r <= 1'b0;
      else     blackout_r <= flush;
   end

   // WB-stage MTC0 forwarding; Cause IP[7:2] always comes from the synchroniser.
   assign status_eff = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) ?
                       bus.wb_cp0_data_i : bus.cp0_status_i;
   assign epc_eff    = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) ?
                       bus.wb_cp0_data_i : bus.cp0_epc_i;
   assign cause_eff  = {bus.cp0_cause_i[31:16], sync_q[SYNC_STAGES-1],
                        (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) ?
                        bus.wb_cp0_data_i[9:8] : bus.cp0_cause_i[9:8],
                        bus.cp0_cause_i[7:0]};

   assign int_pend = status_eff[0] & ~status_eff[1] &
                     (|(cause_eff[15:8] & status_eff[15:8]));

   assign misalign  = (bus.mem_size_i == 2'd1 && bus.mem_addr_i[0]) ||
                      (bus.mem_size_i == 2'd2 && bus.mem_addr_i[1:0] != 2'b00);
   assign load_mis  = bus.mem_read_i  & misalign;
   assign store_mis = bus.mem_write_i & misalign;

   // Reset also suppresses, so nothing flushes while rst is high.
   assign take = bus.inst_valid_i & ~bus.stall_i & ~blackout_r & ~rst;

   // Fixed-priority exception selection.
   always_comb begin
      code     = 32'h0;
      bad_addr = 32'h0;
      if (take) begin
         if (int_pend)                 code = 32'h1;
         else if (bus.exc_flags_i[0]) begin
            code     = 32'h4;
            bad_addr = bus.pc_i;
         end
         else if (bus.exc_flags_i[1]) code = 32'ha;
         else if (bus.exc_flags_i[2]) code = 32'hc;
         else if (bus.exc_flags_i[3]) code = 32'h8;
         else if (bus.exc_flags_i[4]) code = 32'h9;
         else if (load_mis) begin
            code     = 32'h4;
            bad_addr = bus.mem_addr_i;
         end
         else if (store_mis) begin
            code     = 32'h5;
            bad_addr = bus.mem_addr_i;
         end
         else if (bus.exc_flags_i[5]) code = 32'he;
      end
   end

   assign flush                   = (code != 32'h0);
   assign bus.excepttype_o        = code;
   assign bus.bad_addr_o          = bad_addr;
   assign bus.flush_o             = flush;
   assign bus.mem_cancel_o        = flush;
   assign bus.newpc_o             = !flush ? 32'h0 :
                                    (code == 32'he) ? epc_eff : EXC_VECTOR;
   assign bus.current_inst_addr_o = bus.pc_i;
   assign bus.is_in_delayslot_o   = bus.is_in_delayslot_i;
   assign bus.int_sync_o          = sync_q[SYNC_STAGES-1];

   assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16],
                          cause_eff[7:0], bus.cp0_cause_i[15:10]};

endmodule
